// File: rtl/idu.sv
`default_nettype none
// idu: 16-bit instruction decode unit. Small input FIFO feeds a registered
// decoded bundle; accepting a HALT opcode stops intake until reset.
module idu #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       in_instr,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        op,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [15:0]       imm,
  output logic [2:0]        alu_op,
  output logic              reg_we,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              branch,
  output logic              jump,
  output logic              illegal,
  output logic              halted,
  output logic [CNT_W-1:0]  dec_count
);

  localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]  CNT_ONE = 1;
  localparam logic [CNT_W-1:0] DEC_ONE = 1;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             fifo_empty;
  logic             push, pop;
  logic [15:0]      head;

  // Decoded view of the FIFO head, loaded into the output register on pop
  logic [15:0] imm_d;
  logic [2:0]  alu_op_d;
  logic        reg_we_d, mem_rd_d, mem_wr_d, branch_d, jump_d, illegal_d;

  logic              out_valid_q;
  logic [15:0]       word_q;
  logic [15:0]       imm_q;
  logic [2:0]        alu_op_q;
  logic              reg_we_q, mem_rd_q, mem_wr_q, branch_q, jump_q, illegal_q;
  logic [CNT_W-1:0]  dec_count_q;

  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign in_ready   = (count_q < DEPTH_C) && (state_q == RUN);
  assign push       = in_valid && in_ready;
  assign pop        = (!out_valid_q || out_ready) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= in_instr;
  end

  always_comb begin
    imm_d     = 16'h0000;
    alu_op_d  = 3'b000;
    reg_we_d  = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    branch_d  = 1'b0;
    jump_d    = 1'b0;
    illegal_d = 1'b0;
    case (head[15:12])
      4'h1: begin reg_we_d = 1'b1; alu_op_d = 3'b000; end
      4'h2: begin reg_we_d = 1'b1; alu_op_d = 3'b001; end
      4'h3: begin reg_we_d = 1'b1; alu_op_d = 3'b010; end
      4'h4: begin reg_we_d = 1'b1; alu_op_d = 3'b011; end
      4'h5: begin reg_we_d = 1'b1; alu_op_d = 3'b100; end
      4'h6: begin
        reg_we_d = 1'b1;
        imm_d    = {{12{head[3]}}, head[3:0]};
      end
      4'h7: begin
        reg_we_d = 1'b1;
        mem_rd_d = 1'b1;
        imm_d    = {{12{head[3]}}, head[3:0]};
      end
      4'h8: begin
        mem_wr_d = 1'b1;
        imm_d    = {{12{head[3]}}, head[3:0]};
      end
      4'h9: begin
        branch_d = 1'b1;
        alu_op_d = 3'b001;
        imm_d    = {{12{head[3]}}, head[3:0]};
      end
      4'hA: begin
        jump_d = 1'b1;
        imm_d  = {4'h0, head[11:0]};
      end
      4'hB: begin
        reg_we_d = 1'b1;
        imm_d    = {head[7:0], 8'h00};
      end
      4'hC, 4'hD, 4'hE: illegal_d = 1'b1;
      default: ;
    endcase
  end

  // Output register: reload whenever it is free or being consumed; a
  // consumed bundle with nothing behind it drops out_valid but keeps fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      word_q      <= '0;
      imm_q       <= '0;
      alu_op_q    <= '0;
      reg_we_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      word_q      <= head;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      reg_we_q    <= reg_we_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      branch_q    <= branch_d;
      jump_q      <= jump_d;
      illegal_q   <= illegal_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_count_q <= '0;
    end else if (out_valid_q && out_ready) begin
      dec_count_q <= dec_count_q + DEC_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (push && (in_instr[15:12] == 4'hF)) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  assign out_valid = out_valid_q;
  assign op        = word_q[15:12];
  assign rd        = word_q[11:8];
  assign rs1       = word_q[7:4];
  assign rs2       = word_q[3:0];
  assign imm       = imm_q;
  assign alu_op    = alu_op_q;
  assign reg_we    = reg_we_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign branch    = branch_q;
  assign jump      = jump_q;
  assign illegal   = illegal_q;
  assign halted    = (state_q == HALTED) && fifo_empty && !out_valid_q;
  assign dec_count = dec_count_q;

endmodule
`default_nettype wire

// File: tb/tb_idu.sv
`default_nettype none
// tb_idu: directed scenarios plus randomized traffic against a queue-based
// reference model of the decode unit.
module tb_idu;

  localparam int DEPTH = 2;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [15:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    op, rd, rs1, rs2;
  logic [15:0]   imm;
  logic [2:0]    alu_op;
  logic          reg_we, mem_rd, mem_wr, branch, jump, illegal, halted;
  logic [CW-1:0] dec_count;

  idu #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_op(alu_op),
    .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch),
    .jump(jump), .illegal(illegal), .halted(halted), .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  logic [40:0] dut_b;
  assign dut_b = {op, rd, rs1, rs2, imm, alu_op,
                  reg_we, mem_rd, mem_wr, branch, jump, illegal};

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the opcode table
  function automatic logic [40:0] ref_decode(input logic [15:0] w);
    int          o = int'(w[15:12]);
    int          v;
    int          t;
    logic [15:0] im  = 16'h0000;
    logic [2:0]  alu = 3'b000;
    bit          we, mr, mw, br, jp, il;
    we = (o >= 1 && o <= 7) || (o == 11);
    mr = (o == 7);
    mw = (o == 8);
    br = (o == 9);
    jp = (o == 10);
    il = (o >= 12 && o <= 14);
    if (o >= 1 && o <= 5) alu = 3'(o - 1);
    else if (o == 9)      alu = 3'b001;
    if (o >= 6 && o <= 9) begin
      v = int'(w[3:0]);
      if (v > 7) v = v - 16;
      im = 16'(v);
    end else if (o == 10) begin
      im = {4'h0, w[11:0]};
    end else if (o == 11) begin
      t  = int'(w[7:0]) * 256;
      im = 16'(t);
    end
    return {w, im, alu, we, mr, mw, br, jp, il};
  endfunction

  logic [15:0] mq[$];
  bit          m_ov   = 1'b0;
  logic [15:0] m_word = 16'h0000;
  bit          m_halt = 1'b0;
  int          m_cnt  = 0;

  task automatic model_edge();
    bit acc, ld;
    if (rst) begin
      mq.delete();
      m_ov = 0; m_word = 16'h0000; m_halt = 0; m_cnt = 0;
      return;
    end
    acc = in_valid && (mq.size() < DEPTH) && !m_halt;
    ld  = (!m_ov || out_ready) && (mq.size() > 0);
    if (m_ov && out_ready) m_cnt = (m_cnt + 1) % (1 << CW);
    if (ld) begin
      m_word = mq.pop_front();
      m_ov   = 1;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (acc) begin
      mq.push_back(in_instr);
      if (in_instr[15:12] == 4'hF) m_halt = 1;
    end
  endtask

  task automatic step();
    if (in_valid && in_ready && !rst) n_acc++;
    @(posedge clk);
    model_edge();
    #1;
    check("in_ready",  in_ready,  (mq.size() < DEPTH) && !m_halt);
    check("out_valid", out_valid, m_ov);
    check("halted",    halted,    m_halt && (mq.size() == 0) && !m_ov);
    check("dec_count", dec_count, m_cnt);
    check("bundle",    dut_b,     ref_decode(m_word));
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  logic [15:0] w35 [4] = '{16'h1123, 16'h2456, 16'h3789, 16'h4ABC};
  logic [15:0] s38 [3] = '{16'h1231, 16'hF000, 16'h1456};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0000; out_ready = 1'b0;
    step();
    rst = 1'b0;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dec_count", dec_count, 0);
    check("rst_bundle",    dut_b,     0);

    // ADD then ADDI streaming
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h1231;
    step();
    in_instr = 16'h6F4E;
    step();
    check("add_valid", out_valid, 1);
    check("add_fields", {op, rd, rs1, rs2}, 16'h1231);
    check("add_we",    reg_we, 1);
    check("add_alu",   alu_op, 3'b000);
    in_valid = 1'b0;
    step();
    check("addi_imm", imm, 16'hFFFE);
    check("addi_we",  reg_we, 1);

    // Backpressure: four offered, three absorbed
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_instr = w35[(n_acc < 4) ? n_acc : 3];
      step();
    end
    check("bp_accepted", n_acc, 3);
    check("bp_in_ready", in_ready, 0);
    check("bp_hold_op",  op, 4'h1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check("bp_count", dec_count, 3);
    check("bp_drained", out_valid, 0);

    // JMP then LUI
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'hA123;
    step();
    in_instr = 16'hB2C5;
    step();
    check("jmp_jump", jump, 1);
    check("jmp_imm",  imm, 16'h0123);
    in_valid = 1'b0;
    step();
    check("lui_op",  op, 4'hB);
    check("lui_rd",  rd, 4'h2);
    check("lui_imm", imm, 16'hC500);

    // Illegal opcode still delivered
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'hD000;
    step();
    in_valid = 1'b0;
    step();
    check("ill_flag",  illegal, 1);
    check("ill_ctrl",  {reg_we, mem_rd, mem_wr, branch, jump}, 5'b0);
    check("ill_valid", out_valid, 1);
    step();
    check("ill_count", dec_count, 1);

    // HALT blocks the word behind it
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_instr = s38[(n_acc > 2) ? 2 : n_acc];
      step();
    end
    check("halt_accepted", n_acc, 2);
    check("halt_halted",   halted, 1);
    check("halt_in_ready", in_ready, 0);
    check("halt_count",    dec_count, 2);

    // Reset with buffered words discards them
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      in_instr = 16'h1000 + 16'(n_acc);
      step();
    end
    check("mid_full", n_acc, 3);
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    check("mid_out_valid", out_valid, 0);
    check("mid_count",     dec_count, 0);
    check("mid_in_ready",  in_ready, 1);
    out_ready = 1'b1;
    repeat (3) step();
    check("mid_no_stale", out_valid, 0);

    // Long stream to wrap dec_count
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (300) begin
      in_instr = {4'h1, 12'($urandom)};
      step();
    end
    check("wrap_count", dec_count, 42);

    // Randomized traffic
    do_reset();
    repeat (3000) begin
      rst       = ($urandom % 1000 == 0) || (m_halt && ($urandom % 20 == 0));
      in_valid  = ($urandom % 10) < 7;
      out_ready = ($urandom % 10) < 6;
      in_instr  = 16'($urandom);
      if (in_instr[15:12] == 4'hF && ($urandom % 16) != 0)
        in_instr[15:12] = 4'($urandom % 15);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/idu.md
IDU -- requirements
Module: idu

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, instruction buffer entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter CNT_W, default 16, width of dec_count.
REQ-003 clk  in  1  clock; all state updates SHALL occur on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  fetch side presents an instruction word.
REQ-006 in_instr  in  16  instruction word: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4.
REQ-007 in_ready  out  1  idu accepts in_instr this cycle.
REQ-008 out_valid  out  1  decoded bundle valid.
REQ-009 out_ready  in  1  downstream consumes the bundle.
REQ-010 op, rd, rs1, rs2  out  4 each  raw fields of the decoded instruction.
REQ-011 imm  out  16  extended immediate.
REQ-012 alu_op  out  3  ADD=000, SUB=001, AND=010, OR=011, XOR=100.
REQ-013 reg_we, mem_rd, mem_wr, branch, jump, illegal  out  1 each  control flags.
REQ-014 halted  out  1  block stopped after HALT has drained.
REQ-015 dec_count  out  CNT_W  count of bundles delivered.

Function
REQ-016 Opcode map SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 ADDI, 7 LD, 8 ST, 9 BEQ, A JMP, B LUI, C-E illegal, F HALT.
REQ-017 reg_we SHALL be 1 for opcodes 1-7 and B; mem_rd only for 7; mem_wr only for 8; branch only for 9; jump only for A.
REQ-018 alu_op SHALL be the opcode's operation for 1-5, 000 for 6/7/8, 001 for 9, 000 otherwise.
REQ-019 imm: opcodes 6/7/8/9 SHALL give sign-extend([3:0]); A SHALL give zero-extend([11:0]); B SHALL give {[7:0],8'h00}; all others SHALL give 16'h0000.
REQ-020 Opcodes C-E SHALL set illegal=1 with reg_we, mem_rd, mem_wr, branch and jump all 0, and the bundle SHALL still be delivered.
REQ-021 Accept SHALL occur when in_valid && in_ready; the word SHALL be written into the FIFO tail.
REQ-022 in_ready SHALL be (FIFO count < FIFO_DEPTH) && state==RUN; when full there SHALL be no pass-through, even with a simultaneous pop.
REQ-023 The output register SHALL load the decoded FIFO head when !out_valid || out_ready, and FIFO is non-empty; otherwise it SHALL hold all outputs stable.
REQ-024 Latency SHALL be: word accepted at edge N, out_valid=1 after edge N+1 when the output register is free; sustained throughput SHALL be 1 per cycle.
REQ-025 out_valid SHALL fall after a handshake edge if FIFO is empty at that edge.
REQ-026 Simultaneous FIFO push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 State machine SHALL have two states: RUN -> HALTED on acceptance of opcode F; HALTED SHALL be left only by rst.
REQ-028 In HALTED, in_ready SHALL be 0; words already buffered, including the HALT itself, SHALL drain normally.
REQ-029 halted SHALL be 1 when state==HALTED, FIFO is empty and out_valid==0.
REQ-030 dec_count SHALL increment by 1 on each out_valid && out_ready edge, and SHALL wrap from all-ones to 0.

Reset
REQ-031 rst SHALL override all other inputs in the cycle it is sampled.
REQ-032 After rst: FIFO empty, pointers 0, state RUN, out_valid 0, all decoded outputs 0, halted 0, dec_count 0, in_ready 1 in the following cycle.
REQ-033 rst mid-operation SHALL discard buffered and output-register contents without delivering them.

Verification
REQ-034 Stream 16'h1231 (ADD), then 16'h6F4E (ADDI), with out_ready=1 -> first bundle op=1, rd=2, rs1=3, rs2=1, reg_we=1, alu_op=000; second imm=16'hFFFE, reg_we=1.
REQ-035 Backpressure: hold out_ready=0 and offer 4 words -> 3 accepted (2 FIFO + 1 output register), in_ready=0, outputs stable; release -> all 3 delivered in order; dec_count=3.
REQ-036 Words 16'hA123 and 16'hB2C5 -> jump=1, imm=16'h0123; then LUI rd=2, imm=16'hC500.
REQ-037 Word 16'hD000 -> illegal=1, all control flags 0; dec_count increments.
REQ-038 Words ADD, HALT (16'hF000), ADD offered back-to-back -> third word never accepted; ADD and HALT delivered; then halted=1 and in_ready=0 until rst.
REQ-039 Assert rst with 2 words buffered and out_valid=1 -> next cycle out_valid=0, dec_count=0, in_ready=1; no stale bundle ever appears.
